// File: rtl/fc_stream_engine.sv
// Fully-connected layer engine: buffers one activation vector, streams weights per
// neuron, accumulates LANES signed products per beat and emits quantised results.
module fc_stream_engine #(
  parameter int DATA_WIDTH   = 8,
  parameter int WEIGHT_WIDTH = 4,
  parameter int LANES        = 20,
  parameter int MAX_BEATS    = 40,
  parameter int ACC_WIDTH    = 32,
  parameter int CNT_WIDTH    = 10
) (
  input  logic                          clk,
  input  logic                          srstn,
  input  logic                          start,
  input  logic [CNT_WIDTH-1:0]          cfg_in_beats,
  input  logic [CNT_WIDTH-1:0]          cfg_out_len,
  input  logic [4:0]                    cfg_shift,
  input  logic                          cfg_relu,
  input  logic                          act_valid,
  output logic                          act_ready,
  input  logic [LANES*DATA_WIDTH-1:0]   act_data,
  input  logic                          wgt_valid,
  output logic                          wgt_ready,
  input  logic [LANES*WEIGHT_WIDTH-1:0] wgt_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic                          out_last,
  output logic                          busy,
  output logic                          done,
  output logic [1:0]                    dbg_state
);

  // Handshakes: a beat transfers on a rising edge where valid && ready; the
  // producer holds data stable while valid && !ready, and ready never looks at valid.

  localparam int IDX_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
  localparam int PW    = DATA_WIDTH + WEIGHT_WIDTH;
  localparam logic signed [ACC_WIDTH:0] Q_MAX = (ACC_WIDTH+1)'((2 ** (DATA_WIDTH-1)) - 1);
  localparam logic signed [ACC_WIDTH:0] Q_MIN = -Q_MAX - (ACC_WIDTH+1)'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, MAC = 2'd2, DRAIN = 2'd3} state_e;

  state_e                        state_q, state_d;
  logic [CNT_WIDTH-1:0]          beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0]          neuron_cnt_q, neuron_cnt_d;
  logic [CNT_WIDTH-1:0]          in_beats_q, in_beats_d;
  logic [CNT_WIDTH-1:0]          out_len_q, out_len_d;
  logic [4:0]                    shift_q, shift_d;
  logic                          relu_q, relu_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic                          out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]         out_data_q, out_data_d;
  logic                          out_last_q, out_last_d;
  logic                          done_q, done_d;

  logic [LANES*DATA_WIDTH-1:0]   act_buf [MAX_BEATS];
  logic [IDX_W-1:0]              beat_idx;
  logic                          buf_we;
  logic                          cfg_ok;
  logic                          last_beat;
  logic                          last_neuron;
  logic signed [ACC_WIDTH-1:0]   acc_next;

  function automatic logic signed [ACC_WIDTH-1:0] dot_prod(
    input logic [LANES*DATA_WIDTH-1:0]   a,
    input logic [LANES*WEIGHT_WIDTH-1:0] w
  );
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [PW-1:0]        p;
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      p   = PW'($signed(a[i*DATA_WIDTH +: DATA_WIDTH])) *
            PW'($signed(w[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]));
      sum = sum + ACC_WIDTH'(p);
    end
    return sum;
  endfunction

  // Round-half-up right shift, optional ReLU, then saturate to the output width.
  function automatic logic [DATA_WIDTH-1:0] quantise(
    input logic signed [ACC_WIDTH-1:0] x,
    input logic [4:0]                  sh,
    input logic                        relu
  );
    logic signed [ACC_WIDTH:0] r;
    r = (ACC_WIDTH+1)'(x);
    if (sh != 5'd0) r = r + ((ACC_WIDTH+1)'(1) << (sh - 5'd1));
    r = r >>> sh;
    if (relu && r[ACC_WIDTH]) r = '0;
    if (r > Q_MAX)      return Q_MAX[DATA_WIDTH-1:0];
    else if (r < Q_MIN) return Q_MIN[DATA_WIDTH-1:0];
    else                return r[DATA_WIDTH-1:0];
  endfunction

  assign beat_idx    = beat_cnt_q[IDX_W-1:0];
  assign cfg_ok      = (cfg_in_beats != '0) && (cfg_in_beats <= CNT_WIDTH'(MAX_BEATS)) &&
                       (cfg_out_len != '0);
  assign last_beat   = (beat_cnt_q == in_beats_q - CNT_WIDTH'(1));
  assign last_neuron = (neuron_cnt_q == out_len_q - CNT_WIDTH'(1));
  assign acc_next    = ((beat_cnt_q == '0) ? '0 : acc_q) + dot_prod(act_buf[beat_idx], wgt_data);

  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    neuron_cnt_d = neuron_cnt_q;
    in_beats_d   = in_beats_q;
    out_len_d    = out_len_q;
    shift_d      = shift_q;
    relu_d       = relu_q;
    acc_d        = acc_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    done_d       = 1'b0;
    act_ready    = 1'b0;
    wgt_ready    = 1'b0;
    buf_we       = 1'b0;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && cfg_ok) begin
          in_beats_d   = cfg_in_beats;
          out_len_d    = cfg_out_len;
          shift_d      = cfg_shift;
          relu_d       = cfg_relu;
          beat_cnt_d   = '0;
          neuron_cnt_d = '0;
          state_d      = LOAD;
        end
      end
      LOAD: begin
        act_ready = 1'b1;
        if (act_valid) begin
          buf_we = 1'b1;
          if (last_beat) begin
            beat_cnt_d = '0;
            state_d    = MAC;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      MAC: begin
        // A result draining this cycle frees the register for the next one.
        wgt_ready = !(out_valid_q && !out_ready);
        if (wgt_valid && wgt_ready) begin
          acc_d = acc_next;
          if (last_beat) begin
            beat_cnt_d  = '0;
            out_valid_d = 1'b1;
            out_data_d  = quantise(acc_next, shift_q, relu_q);
            out_last_d  = last_neuron;
            if (last_neuron) state_d = DRAIN;
            else             neuron_cnt_d = neuron_cnt_q + CNT_WIDTH'(1);
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      DRAIN: begin
        if (out_valid_q && out_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge srstn) begin
    if (!srstn) begin
      state_q      <= IDLE;
      beat_cnt_q   <= '0;
      neuron_cnt_q <= '0;
      in_beats_q   <= '0;
      out_len_q    <= '0;
      shift_q      <= '0;
      relu_q       <= 1'b0;
      acc_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      neuron_cnt_q <= neuron_cnt_d;
      in_beats_q   <= in_beats_d;
      out_len_q    <= out_len_d;
      shift_q      <= shift_d;
      relu_q       <= relu_d;
      acc_q        <= acc_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      done_q       <= done_d;
    end
  end

  // Activation buffer is plain storage; every layer rewrites it before use.
  always_ff @(posedge clk) begin
    if (buf_we) act_buf[beat_idx] <= act_data;
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fc_stream_engine.sv
// Directed bench for fc_stream_engine: hand-computed layers, backpressure, illegal
// starts, mid-load reset, and a long randomly stalled layer checked against a model.
module tb_fc_stream_engine;

  localparam int DW        = 8;
  localparam int WW        = 4;
  localparam int LANES     = 20;
  localparam int MAX_BEATS = 40;
  localparam int ACC_WIDTH = 32;
  localparam int CNT_WIDTH = 10;
  localparam int LIMIT     = 4000;
  localparam int OUT_LIMIT = 40000;

  // ---------------- clock / reset / DUT ----------------
  logic                    clk = 1'b0;
  logic                    srstn;
  logic                    start;
  logic [CNT_WIDTH-1:0]    cfg_in_beats;
  logic [CNT_WIDTH-1:0]    cfg_out_len;
  logic [4:0]              cfg_shift;
  logic                    cfg_relu;
  logic                    act_valid;
  logic                    act_ready;
  logic [LANES*DW-1:0]     act_data;
  logic                    wgt_valid;
  logic                    wgt_ready;
  logic [LANES*WW-1:0]     wgt_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [DW-1:0]           out_data;
  logic                    out_last;
  logic                    busy;
  logic                    done;
  logic [1:0]              dbg_state;

  always #5 clk = ~clk;

  fc_stream_engine #(
    .DATA_WIDTH(DW), .WEIGHT_WIDTH(WW), .LANES(LANES), .MAX_BEATS(MAX_BEATS),
    .ACC_WIDTH(ACC_WIDTH), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk(clk), .srstn(srstn), .start(start),
    .cfg_in_beats(cfg_in_beats), .cfg_out_len(cfg_out_len),
    .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
    .wgt_valid(wgt_valid), .wgt_ready(wgt_ready), .wgt_data(wgt_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [LANES*DW-1:0] act_beats [MAX_BEATS];
  logic [LANES*WW-1:0] wgt_q [$];
  logic [DW-1:0]       exp_q [$];
  int                  tests_run    = 0;
  int                  tests_failed = 0;
  int                  done_cnt     = 0;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests_run++;
    assert (obs === expv) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // ---------------- stimulus helpers ----------------
  function automatic logic [LANES*DW-1:0] rep_act(input logic [DW-1:0] v);
    logic [LANES*DW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*DW +: DW] = v;
    return r;
  endfunction

  function automatic logic [LANES*WW-1:0] rep_wgt(input logic [WW-1:0] v);
    logic [LANES*WW-1:0] r;
    for (int l = 0; l < LANES; l++) r[l*WW +: WW] = v;
    return r;
  endfunction

  task automatic rand_data(input int in_beats, input int out_len);
    logic [LANES*DW-1:0] a;
    logic [LANES*WW-1:0] w;
    for (int b = 0; b < in_beats; b++) begin
      for (int l = 0; l < LANES; l++) a[l*DW +: DW] = DW'($urandom_range(0, 255));
      act_beats[b] = a;
    end
    for (int k = 0; k < in_beats * out_len; k++) begin
      for (int l = 0; l < LANES; l++) w[l*WW +: WW] = WW'($urandom_range(0, 15));
      wgt_q.push_back(w);
    end
  endtask

  // Reference model: exact integer dot product, then round/ReLU/saturate.
  function automatic logic [DW-1:0] quant(input longint acc, input int shift, input bit relu);
    longint r;
    r = acc;
    if (shift > 0) r = r + (longint'(1) << (shift - 1));
    r = r >>> shift;
    if (relu && r < 0) r = 0;
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return r[DW-1:0];
  endfunction

  task automatic build_expected(input int in_beats, input int out_len, input int shift,
                                input bit relu);
    longint               acc;
    logic signed [DW-1:0] a;
    logic signed [WW-1:0] w;
    logic [LANES*WW-1:0]  wb;
    for (int n = 0; n < out_len; n++) begin
      acc = 0;
      for (int b = 0; b < in_beats; b++) begin
        wb = wgt_q[n*in_beats + b];
        for (int l = 0; l < LANES; l++) begin
          a   = act_beats[b][l*DW +: DW];
          w   = wb[l*WW +: WW];
          acc = acc + longint'(a) * longint'(w);
        end
      end
      exp_q.push_back(quant(acc, shift, relu));
    end
  endtask

  // ---------------- driver tasks (enter/leave at posedge+1) ----------------
  task automatic send_act(input logic [LANES*DW-1:0] d, input bit stall);
    int n = 0;
    int g;
    g = stall ? $urandom_range(0, 1) : 0;
    repeat (g) begin @(posedge clk); #1; end
    act_valid = 1'b1;
    act_data  = d;
    @(negedge clk);
    while (!act_ready && n < LIMIT) begin @(negedge clk); n++; end
    check("act_accept", act_ready, 1);
    @(posedge clk); #1;
    act_valid = 1'b0;
  endtask

  task automatic send_wgt(input logic [LANES*WW-1:0] d, input bit stall);
    int n = 0;
    int g;
    g = stall ? $urandom_range(0, 1) : 0;
    repeat (g) begin @(posedge clk); #1; end
    wgt_valid = 1'b1;
    wgt_data  = d;
    @(negedge clk);
    while (!wgt_ready && n < LIMIT) begin @(negedge clk); n++; end
    check("wgt_accept", wgt_ready, 1);
    @(posedge clk); #1;
    wgt_valid = 1'b0;
  endtask

  // mode 0: out_ready=1, mode 1: random out_ready, mode 2: hold 10 cycles on first result
  task automatic monitor(input int out_len, input int mode);
    int            n_out  = 0;
    int            cyc    = 0;
    int            bp_cnt = 0;
    logic [DW-1:0] held;
    logic [DW-1:0] exp_v;
    held = (exp_q.size() != 0) ? exp_q[0] : 'x;
    while (n_out < out_len && cyc < OUT_LIMIT) begin
      @(negedge clk);
      cyc++;
      if (mode == 2 && bp_cnt < 10 && out_valid) begin
        check("bp_wgt_ready", wgt_ready, 0);
        check("bp_out_stable", out_data, held);
        bp_cnt++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() != 0) exp_v = exp_q.pop_front();
        else                   exp_v = 'x;
        check("out_data", out_data, exp_v);
        check("out_last", out_last, n_out == out_len - 1);
        n_out++;
      end
      @(posedge clk); #1;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = (bp_cnt >= 10);
      endcase
    end
    check("out_count", n_out, out_len);
  endtask

  task automatic inject_start();
    int                   n = 0;
    logic [CNT_WIDTH-1:0] sv_in, sv_out;
    logic [4:0]           sv_sh;
    @(negedge clk);
    while (dbg_state !== 2'd2 && n < LIMIT) begin @(negedge clk); n++; end
    check("inject_in_mac", dbg_state, 2);
    @(posedge clk); #1;
    sv_in = cfg_in_beats; sv_out = cfg_out_len; sv_sh = cfg_shift;
    cfg_in_beats = 1; cfg_out_len = 1; cfg_shift = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_in_beats = sv_in; cfg_out_len = sv_out; cfg_shift = sv_sh;
  endtask

  task automatic run_layer(input int in_beats, input int out_len, input int shift,
                           input bit relu, input int mode, input bit inject);
    int d0;
    bit stall;
    stall     = (mode == 1);
    d0        = done_cnt;
    out_ready = (mode != 2);
    @(posedge clk); #1;
    cfg_in_beats = CNT_WIDTH'(in_beats);
    cfg_out_len  = CNT_WIDTH'(out_len);
    cfg_shift    = 5'(shift);
    cfg_relu     = relu;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("act_ready_after_start", act_ready, 1);
    fork
      for (int b = 0; b < in_beats; b++) send_act(act_beats[b], stall);
      for (int k = 0; k < in_beats * out_len; k++) send_wgt(wgt_q[k], stall);
      monitor(out_len, mode);
      if (inject) inject_start();
    join
    check("done_pulse", done, 1);
    check("busy_at_done", busy, 0);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("done_count", done_cnt - d0, 1);
    wgt_q.delete();
    exp_q.delete();
  endtask

  task automatic try_illegal(input int in_beats, input int out_len);
    @(posedge clk); #1;
    cfg_in_beats = CNT_WIDTH'(in_beats);
    cfg_out_len  = CNT_WIDTH'(out_len);
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("illegal_busy", busy, 0);
    check("illegal_act_ready", act_ready, 0);
    @(posedge clk); #1;
    check("illegal_busy_later", busy, 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [LANES*DW-1:0] a;
    srstn = 1'b0; start = 1'b0;
    cfg_in_beats = '0; cfg_out_len = '0; cfg_shift = '0; cfg_relu = 1'b0;
    act_valid = 1'b0; act_data = '0; wgt_valid = 1'b0; wgt_data = '0; out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_act_ready", act_ready, 0);
    check("rst_wgt_ready", wgt_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", dbg_state, 0);
    srstn = 1'b1;

    // Reset in the middle of loading: three of five beats, then async reset.
    @(posedge clk); #1;
    cfg_in_beats = 5; cfg_out_len = 1; cfg_shift = 0; cfg_relu = 0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int b = 0; b < 3; b++) send_act(rep_act(8'd1), 1'b0);
    #2;
    srstn = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_act_ready", act_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_done", done, 0);
    check("midrst_state", dbg_state, 0);
    @(posedge clk); #1;
    srstn = 1'b1;

    // Basic layer: all-ones activations, +1 then -1 weights.
    act_beats[0] = rep_act(8'd1);
    wgt_q.push_back(rep_wgt(4'h1));
    wgt_q.push_back(rep_wgt(4'hF));
    exp_q.push_back(8'd20);
    exp_q.push_back(8'hEC);
    run_layer(1, 2, 0, 1'b0, 0, 1'b0);

    act_beats[0] = rep_act(8'd1);
    wgt_q.push_back(rep_wgt(4'h1));
    wgt_q.push_back(rep_wgt(4'hF));
    exp_q.push_back(8'd20);
    exp_q.push_back(8'd0);
    run_layer(1, 2, 0, 1'b1, 0, 1'b0);

    // 127*7*40 = 35560: shift 8 -> 139 saturates to 127, shift 9 -> 69.
    act_beats[0] = rep_act(8'd127);
    act_beats[1] = rep_act(8'd127);
    wgt_q.push_back(rep_wgt(4'd7));
    wgt_q.push_back(rep_wgt(4'd7));
    exp_q.push_back(8'd127);
    run_layer(2, 1, 8, 1'b0, 0, 1'b0);

    act_beats[0] = rep_act(8'd127);
    act_beats[1] = rep_act(8'd127);
    wgt_q.push_back(rep_wgt(4'd7));
    wgt_q.push_back(rep_wgt(4'd7));
    exp_q.push_back(8'd69);
    run_layer(2, 1, 9, 1'b0, 0, 1'b0);

    // Rounding with a single live lane: -3 >> 1 -> -1, +3 >> 1 -> 2.
    a = '0;
    a[DW-1:0] = 8'd3;
    act_beats[0] = a;
    wgt_q.push_back(rep_wgt(4'hF));
    wgt_q.push_back(rep_wgt(4'h1));
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'd2);
    run_layer(1, 2, 1, 1'b0, 0, 1'b0);

    // Backpressure on the first result for 10 cycles.
    rand_data(2, 4);
    build_expected(2, 4, 5, 1'b0);
    run_layer(2, 4, 5, 1'b0, 2, 1'b0);

    try_illegal(0, 3);
    try_illegal(MAX_BEATS + 1, 3);
    try_illegal(2, 0);

    // Long layer with random stalls on every stream and a stray start mid-MAC.
    rand_data(40, 120);
    build_expected(40, 120, 7, 1'b0);
    run_layer(40, 120, 7, 1'b0, 1, 1'b1);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
